// File: rtl/pc_gen.sv
// pc_gen: fetch-stage program counter with trap/redirect/stall priority and a return-address stack
module pc_gen #(
    parameter int unsigned             XLEN      = 32,
    parameter logic [XLEN-1:0]         RESET_VEC = '0,
    parameter logic [XLEN-1:0]         TRAP_VEC  = 'h80,
    parameter int unsigned             INC       = 4,
    parameter int unsigned             RAS_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           stall,
    input  logic                           trap,
    input  logic                           redirect_valid,
    input  logic [XLEN-1:0]                redirect_pc,
    input  logic                           ras_push,
    input  logic                           ras_pop,
    output logic [XLEN-1:0]                out_pc,
    output logic [XLEN-1:0]                out_pc_plus,
    output logic [$clog2(RAS_DEPTH):0]     ras_count,
    output logic                           ras_empty,
    output logic                           ras_full
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    logic [XLEN-1:0] ras [RAS_DEPTH];
    logic [PW-1:0]   ptr, ptr_n, wr_idx;
    logic [CW-1:0]   cnt_n;
    logic [XLEN-1:0] pc_n, top_pc;
    logic            do_op, pop_ok, push_ok;

    assign out_pc_plus = out_pc + XLEN'(INC);
    assign ras_empty   = ras_count == '0;
    assign ras_full    = ras_count == CW'(RAS_DEPTH);
    assign top_pc      = ras[ptr];

    // next-state selection: trap > redirect > stall > pop > sequential
    always_comb begin
        do_op   = !trap && !redirect_valid && !stall;
        pop_ok  = do_op && ras_pop && !ras_empty;
        push_ok = do_op && ras_push;
        pc_n    = trap ? TRAP_VEC :
                  redirect_valid ? (redirect_pc & ~XLEN'(INC - 1)) :
                  stall ? out_pc :
                  pop_ok ? top_pc : out_pc_plus;
        ptr_n   = trap ? '0 :
                  (push_ok && !pop_ok) ? ptr + PW'(1) :
                  (pop_ok && !push_ok) ? ptr - PW'(1) : ptr;
        cnt_n   = trap ? '0 :
                  (push_ok && !pop_ok) ? (ras_full ? ras_count : ras_count + CW'(1)) :
                  (pop_ok && !push_ok) ? ras_count - CW'(1) : ras_count;
        wr_idx  = pop_ok ? ptr : ptr + PW'(1);
    end

    // PC, stack pointer and occupancy registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_pc    <= RESET_VEC;
            ptr       <= '0;
            ras_count <= '0;
        end else begin
            out_pc    <= pc_n;
            ptr       <= ptr_n;
            ras_count <= cnt_n;
        end
    end

    // stack storage; a push with a concurrent pop replaces the top in place
    always_ff @(posedge clk) begin
        if (push_ok) ras[wr_idx] <= out_pc_plus;
    end
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed vectors for pc_gen with hand-computed expectations
module tb_pc_gen;
    logic        clk = 1'b0;
    logic        reset, stall, trap, redirect_valid, ras_push, ras_pop;
    logic [31:0] redirect_pc, out_pc, out_pc_plus;
    logic [2:0]  ras_count;
    logic        ras_empty, ras_full;
    int          n_tests = 0;
    int          n_fail  = 0;

    pc_gen dut (
        .clk(clk), .reset(reset), .stall(stall), .trap(trap),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .ras_push(ras_push), .ras_pop(ras_pop), .out_pc(out_pc),
        .out_pc_plus(out_pc_plus), .ras_count(ras_count),
        .ras_empty(ras_empty), .ras_full(ras_full)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall = 0; trap = 0; redirect_valid = 0; ras_push = 0; ras_pop = 0;
    endtask

    task automatic jump(input logic [31:0] a);
        redirect_valid = 1; redirect_pc = a;
        step();
        redirect_valid = 0;
    endtask

    initial begin
        reset = 1; redirect_pc = 0;
        idle();
        step(); step();
        check("rst_pc", out_pc, 32'h0);
        check("rst_cnt", 32'(ras_count), 0);
        check("rst_empty", 32'(ras_empty), 1);
        reset = 0;
        step(); check("seq1", out_pc, 32'h4);
        step(); check("seq2", out_pc, 32'h8);
        step(); check("seq3", out_pc, 32'hC);
        check("seq_plus", out_pc_plus, 32'h10);
        step(); check("seq4", out_pc, 32'h10);
        stall = 1;
        step(); check("stall1", out_pc, 32'h10);
        step(); check("stall2", out_pc, 32'h10);
        redirect_valid = 1; redirect_pc = 32'h203;
        step(); check("redir_over_stall", out_pc, 32'h200);
        idle();
        jump(32'h40); check("jump40", out_pc, 32'h40);
        ras_push = 1;
        step(); check("call_pc", out_pc, 32'h44);
        check("call_cnt", 32'(ras_count), 1);
        ras_push = 0;
        step(); check("after_call", out_pc, 32'h48);
        ras_pop = 1;
        step(); check("ret_pc", out_pc, 32'h44);
        check("ret_cnt", 32'(ras_count), 0);
        ras_pop = 0;
        jump(32'h100);
        ras_pop = 1;
        step(); check("pop_empty_pc", out_pc, 32'h104);
        check("pop_empty_cnt", 32'(ras_count), 0);
        ras_pop = 0;
        jump(32'h0);
        ras_push = 1;
        for (int i = 1; i <= 5; i++) begin
            step(); check("ovf_pc", out_pc, 32'(4 * i));
        end
        check("ovf_cnt", 32'(ras_count), 4);
        check("ovf_full", 32'(ras_full), 1);
        ras_push = 0; ras_pop = 1;
        step(); check("ovf_pop1", out_pc, 32'h14);
        step(); check("ovf_pop2", out_pc, 32'h10);
        step(); check("ovf_pop3", out_pc, 32'hC);
        step(); check("ovf_pop4", out_pc, 32'h8);
        check("ovf_empty", 32'(ras_empty), 1);
        ras_pop = 0; ras_push = 1;
        step(); step(); step();
        check("pre_trap_cnt", 32'(ras_count), 3);
        trap = 1; redirect_valid = 1; redirect_pc = 32'h300; stall = 1; ras_pop = 1;
        step(); check("trap_pc", out_pc, 32'h80);
        check("trap_cnt", 32'(ras_count), 0);
        idle();
        step(); check("post_trap", out_pc, 32'h84);
        reset = 1;
        #2;
        check("async_rst_pc", out_pc, 32'h0);
        check("async_rst_cnt", 32'(ras_count), 0);
        step();
        reset = 0;
        step(); check("post_rst", out_pc, 32'h4);
        jump(32'hFFFF_FFFC);
        check("wrap_plus", out_pc_plus, 32'h0);
        step(); check("wrap_pc", out_pc, 32'h0);
        ras_push = 1;
        step(); check("pp_setup", out_pc, 32'h4);
        ras_pop = 1;
        step(); check("pp_pc", out_pc, 32'h4);
        check("pp_cnt", 32'(ras_count), 1);
        ras_push = 0;
        step(); check("pp_newtop", out_pc, 32'h8);
        check("pp_cnt0", 32'(ras_count), 0);
        ras_push = 1;
        step(); check("pp_empty_pc", out_pc, 32'hC);
        check("pp_empty_cnt", 32'(ras_count), 1);
        idle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the pipelined processor's fetch stage. It holds the fetch PC, advances it sequentially, honours hazard stalls, and applies trap and branch/jump redirects with fixed priority. A small return-address stack (RAS) predicts return targets. It supersedes the single-width, hold/load-only PC register.

## Interface
Parameters:
- XLEN, 32: PC width in bits.
- RESET_VEC, 0: PC value on reset.
- TRAP_VEC, 32'h0000_0080: PC loaded on trap (truncated to XLEN).
- INC, 4: sequential increment in bytes; power of 2.
- RAS_DEPTH, 4: RAS entries; power of 2, ≥2.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  hazard hold; PC and RAS frozen.
- trap  in  1  exception; next PC = TRAP_VEC; RAS cleared.
- redirect_valid  in  1  resolved branch/jump taken.
- redirect_pc  in  XLEN  redirect target; low log2(INC) bits forced to 0.
- ras_push  in  1  call predicted at out_pc; push out_pc+INC.
- ras_pop  in  1  return predicted at out_pc; next PC = RAS top.
- out_pc  out  XLEN  registered fetch PC.
- out_pc_plus  out  XLEN  combinational out_pc+INC, modulo 2^XLEN.
- ras_count  out  clog2(RAS_DEPTH)+1  valid RAS entries.
- ras_empty  out  1  ras_count==0.
- ras_full  out  1  ras_count==RAS_DEPTH.

## Operation
- Next-PC priority, highest first: reset > trap > redirect_valid > stall > ras_pop (RAS non-empty) > sequential.
- reset: out_pc=RESET_VEC, ras_count=0, RAS pointer=0, entries don't-care; asserted asynchronously, released synchronously to clk.
- trap: out_pc←TRAP_VEC; ras_count←0. Ignores stall, redirect, push and pop.
- redirect_valid (no trap): out_pc←redirect_pc & ~(INC-1). RAS unchanged; push/pop ignored that cycle.
- stall (no trap/redirect): out_pc holds; push/pop ignored.
- Otherwise:
  - pop with non-empty RAS: out_pc←top; count−1.
  - pop with empty RAS: treated as sequential, count stays 0 (no underflow).
  - push only: out_pc←out_pc+INC; write out_pc+INC at top+1; count+1, saturating at RAS_DEPTH.
  - push when full: circular overwrite of the oldest entry, count stays RAS_DEPTH.
  - push and pop together, RAS non-empty: out_pc←old top; top entry replaced by out_pc+INC; count unchanged.
  - push and pop together, RAS empty: behaves as push only.
  - neither push nor pop: out_pc←out_pc+INC.
- PC arithmetic wraps modulo 2^XLEN; no overflow flag.
- RAS is a circular buffer with a single top pointer. Pop decrements the pointer, push increments it, both mod RAS_DEPTH.

## Timing
- One-cycle latency: inputs sampled on edge N; out_pc reflects them after edge N.
- ras_count, ras_empty and ras_full are registered-state-derived and valid the cycle after the push/pop.
- RAS top read is combinational from registered state; pop target equals the entry present before edge N.
- No handshake; all control inputs are single-cycle level qualifiers sampled every edge.
- Reset asserted mid-operation clears out_pc and RAS immediately, without waiting for clk.

## Test plan
- Reset/sequential: reset high, then low for 3 cycles -> out_pc=0 during reset, then 4, 8, 12; out_pc_plus=16.
- Stall vs redirect: at out_pc=0x10, stall=1 for 2 cycles -> out_pc stays 0x10. Then stall=1 with redirect_valid=1 and redirect_pc=0x203 -> out_pc=0x200.
- Call/return: push at 0x40, sequential to 0x48, pop -> out_pc=0x44, ras_count 1→0. Pop on empty at 0x100 -> out_pc=0x104, count 0.
- RAS overflow with RAS_DEPTH=4: 5 pushes at 0x0,0x4,...,0x10 (returns 0x4..0x14), ras_full=1. Four pops -> targets 0x14, 0x10, 0xC, 0x8, then ras_empty=1.
- Trap priority: trap=1 with redirect_valid=1, stall=1, ras_count=3 -> out_pc=0x80, ras_count=0. Async reset mid-cycle -> out_pc=0 before the next edge.
- Wrap, XLEN=32: out_pc=0xFFFF_FFFC, no control asserted -> out_pc=0x0; push/pop in same cycle -> count unchanged, out_pc=old top.
